alu_issue_stage: RTL and testbench

- Decode/issue register that sits directly upstream of the combinational ALU.
- Decodes an RV32I instruction into the ALU's 4-bit op encoding and selects both operands.
- Registers the result into the ID/EX pipeline slot under a valid/ready handshake, with stall and flush support.
- Its outputs drive the ALU's op_a, op_b and alu_op inputs unmodified.

---
 rtl/alu_issue_stage.sv | 149 ++++++++++++++
 tb/tb_alu_issue_stage.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: RV32I decode/issue register that feeds the combinational ALU.
//   Optional macro ALU_ISSUE_PERF_EN adds issue/stall performance counters.
//   Ports:
//     i_clk, i_rst_n                  clock (rising edge), async active-low reset
//     i_valid, o_ready                upstream handshake (o_ready = ~o_valid | i_ready)
//     i_instr, i_pc                   instruction word and its PC
//     i_rs1_data, i_rs2_data          register file read values
//     i_flush                         drop slot contents and the current input
//     o_valid, i_ready                downstream (EX) handshake
//     o_alu_op, o_op_a, o_op_b        ALU op code and operands
//     o_rd, o_rd_wren, o_pc           destination, writeback enable, registered PC
//     o_illegal                       unsupported encoding flag
//     o_issue_cnt, o_stall_cnt        drain handshakes / stalled cycles (perf build only)
module alu_issue_stage #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [31:0]       i_instr,
  input  logic [DATA_W-1:0] i_pc,
  input  logic [DATA_W-1:0] i_rs1_data,
  input  logic [DATA_W-1:0] i_rs2_data,
  input  logic              i_flush,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [3:0]        o_alu_op,
  output logic [DATA_W-1:0] o_op_a,
  output logic [DATA_W-1:0] o_op_b,
  output logic [4:0]        o_rd,
  output logic              o_rd_wren,
  output logic [DATA_W-1:0] o_pc,
  output logic              o_illegal
`ifdef ALU_ISSUE_PERF_EN
  ,
  output logic [CNT_W-1:0]  o_issue_cnt,
  output logic [CNT_W-1:0]  o_stall_cnt
`endif
);
  if (DATA_W != 32 || CNT_W < 1) begin : g_bad_cfg
    $error("alu_issue_stage supports only DATA_W=32 and CNT_W>=1");
  end
  logic              r_valid;
  logic [3:0]        r_alu_op;
  logic [DATA_W-1:0] r_op_a;
  logic [DATA_W-1:0] r_op_b;
  logic [4:0]        r_rd;
  logic              r_rd_wren;
  logic [DATA_W-1:0] r_pc;
  logic              r_illegal;
  logic [6:0]        w_opc;
  logic [2:0]        w_f3;
  logic [6:0]        w_f7;
  logic [4:0]        w_rd;
  logic              w_is_op, w_is_opi, w_is_lui, w_is_auipc, w_is_jal, w_is_jalr;
  logic              w_is_load, w_is_store, w_is_br;
  logic              w_op_legal, w_opi_legal, w_legal, w_cap;
  logic [DATA_W-1:0] w_imm_i, w_imm_s, w_imm_u;
  logic [3:0]        w_alu_op;
  logic [DATA_W-1:0] w_op_a, w_op_b;
  logic              w_rd_wren;
  assign w_opc      = i_instr[6:0];
  assign w_rd       = i_instr[11:7];
  assign w_f3       = i_instr[14:12];
  assign w_f7       = i_instr[31:25];
  assign w_is_op    = w_opc == 7'b0110011;
  assign w_is_opi   = w_opc == 7'b0010011;
  assign w_is_lui   = w_opc == 7'b0110111;
  assign w_is_auipc = w_opc == 7'b0010111;
  assign w_is_jal   = w_opc == 7'b1101111;
  assign w_is_jalr  = w_opc == 7'b1100111;
  assign w_is_load  = w_opc == 7'b0000011;
  assign w_is_store = w_opc == 7'b0100011;
  assign w_is_br    = w_opc == 7'b1100011;
  assign w_imm_i    = {{20{i_instr[31]}}, i_instr[31:20]};
  assign w_imm_s    = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
  assign w_imm_u    = {i_instr[31:12], 12'h000};
  // f7 bit 5 only selects SUB/SRA; every other f7 pattern is reserved
  assign w_op_legal  = w_f7 == 7'b0000000 || (w_f7 == 7'b0100000 && (w_f3 == 3'b000 || w_f3 == 3'b101));
  assign w_opi_legal = w_f3 == 3'b001 ? w_f7 == 7'b0000000 :
                       w_f3 == 3'b101 ? (w_f7 == 7'b0000000 || w_f7 == 7'b0100000) : 1'b1;
  assign w_legal = (w_is_op & w_op_legal) | (w_is_opi & w_opi_legal) | w_is_lui | w_is_auipc |
                   w_is_jal | w_is_jalr | w_is_load | w_is_store | w_is_br;
  // OP-IMM f3=000 must stay ADD even though imm[10] lands in f7[5]
  assign w_alu_op = !w_legal ? 4'b0000 :
                    w_is_op ? {w_f7[5], w_f3} :
                    w_is_opi ? {w_f3 == 3'b101 && w_f7[5], w_f3} :
                    w_is_lui ? 4'b1111 :
                    w_is_br ? 4'b1000 : 4'b0000;
  assign w_op_a = !w_legal || w_is_lui ? '0 :
                  (w_is_auipc | w_is_jal | w_is_jalr) ? i_pc : i_rs1_data;
  assign w_op_b = !w_legal ? '0 :
                  (w_is_op | w_is_br) ? i_rs2_data :
                  (w_is_opi | w_is_load) ? w_imm_i :
                  w_is_store ? w_imm_s :
                  (w_is_lui | w_is_auipc) ? w_imm_u : DATA_W'(4);
  assign w_rd_wren = w_legal & ~(w_is_store | w_is_br) & (|w_rd);
  assign o_ready   = ~r_valid | i_ready;
  assign w_cap     = i_valid & o_ready & ~i_flush;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid   <= 1'b0;
      r_alu_op  <= '0;
      r_op_a    <= '0;
      r_op_b    <= '0;
      r_rd      <= '0;
      r_rd_wren <= 1'b0;
      r_pc      <= '0;
      r_illegal <= 1'b0;
    end else begin
      // flush wins; otherwise a capture refills, a stall holds, a drain empties
      r_valid <= ~i_flush & (w_cap | (r_valid & ~i_ready));
      if (w_cap) begin
        r_alu_op  <= w_alu_op;
        r_op_a    <= w_op_a;
        r_op_b    <= w_op_b;
        r_rd      <= w_rd;
        r_rd_wren <= w_rd_wren;
        r_pc      <= i_pc;
        r_illegal <= ~w_legal;
      end
    end
  end
  assign o_valid   = r_valid;
  assign o_alu_op  = r_alu_op;
  assign o_op_a    = r_op_a;
  assign o_op_b    = r_op_b;
  assign o_rd      = r_rd;
  assign o_rd_wren = r_rd_wren;
  assign o_pc      = r_pc;
  assign o_illegal = r_illegal;
`ifdef ALU_ISSUE_PERF_EN
  logic [CNT_W-1:0] r_issue_cnt, r_stall_cnt;
  // counters survive flush; they wrap naturally at all-ones
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_issue_cnt <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (r_valid & i_ready) r_issue_cnt <= r_issue_cnt + 1'b1;
      if (r_valid & ~i_ready) r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end
  assign o_issue_cnt = r_issue_cnt;
  assign o_stall_cnt = r_stall_cnt;
`endif
endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: vector table, corner sequences and random traffic against a decode model.
module tb_alu_issue_stage;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_valid = 1'b0, i_flush = 1'b0, i_ready = 1'b0;
  logic [31:0] instr = '0, pc = '0, rs1 = '0, rs2 = '0;
  logic        o_ready, o_valid, o_rd_wren, o_illegal;
  logic [3:0]  o_alu_op;
  logic [31:0] o_op_a, o_op_b, o_pc;
  logic [4:0]  o_rd;
`ifdef ALU_ISSUE_PERF_EN
  logic [31:0] o_issue_cnt, o_stall_cnt;
`endif
  alu_issue_stage dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_instr(instr), .i_pc(pc), .i_rs1_data(rs1), .i_rs2_data(rs2),
    .i_flush(i_flush), .o_valid(o_valid), .i_ready(i_ready),
    .o_alu_op(o_alu_op), .o_op_a(o_op_a), .o_op_b(o_op_b), .o_rd(o_rd),
    .o_rd_wren(o_rd_wren), .o_pc(o_pc), .o_illegal(o_illegal)
`ifdef ALU_ISSUE_PERF_EN
    , .o_issue_cnt(o_issue_cnt), .o_stall_cnt(o_stall_cnt)
`endif
  );
  always #5 clk = ~clk;
  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic        wren;
    logic [31:0] pc;
    logic        ill;
  } dec_t;
  typedef struct {
    logic [31:0] instr, pc, rs1, rs2;
    dec_t        exp;
  } vec_t;
  dec_t        w_act;
  assign w_act = {o_alu_op, o_op_a, o_op_b, o_rd, o_rd_wren, o_pc, o_illegal};
  int          checks = 0, errors = 0;
  logic        m_valid = 1'b0;
  dec_t        m_out = '0;
  logic [31:0] m_issue = '0, m_stall = '0;
  vec_t        vt[14];
  function automatic vec_t mk(logic [31:0] ins, p, r1, r2, logic [3:0] op, logic [31:0] a, b,
                              logic [4:0] rd, logic wr, logic il);
    vec_t v;
    v.instr = ins; v.pc = p; v.rs1 = r1; v.rs2 = r2;
    v.exp = '{op: op, a: a, b: b, rd: rd, wren: wr, pc: p, ill: il};
    return v;
  endfunction
  // Architectural decode straight from the RV32I opcode map
  function automatic dec_t ref_dec(logic [31:0] ins, p, r1, r2);
    dec_t d;
    logic signed [31:0] s;
    logic [31:0] ii, is_, iu;
    logic [2:0] f3;
    logic [6:0] f7;
    logic ok, wr;
    s = ins;
    ii = s >>> 20;
    is_ = {ii[31:5], ins[11:7]};
    iu = ins & 32'hFFFFF000;
    f3 = ins[14:12];
    f7 = ins[31:25];
    d = '{op: 4'h0, a: 32'h0, b: 32'h0, rd: ins[11:7], wren: 1'b0, pc: p, ill: 1'b0};
    ok = 1'b1;
    wr = 1'b1;
    case (ins[6:0])
      7'h33: begin
        ok = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
        d.op = {f7[5], f3}; d.a = r1; d.b = r2;
      end
      7'h13: begin
        d.a = r1; d.b = ii; d.op = {1'b0, f3};
        if (f3 == 3'd1) ok = f7 == 7'h00;
        if (f3 == 3'd5) begin
          ok = f7 == 7'h00 || f7 == 7'h20;
          d.op = (f7 == 7'h20) ? 4'hD : 4'h5;
        end
      end
      7'h37: begin d.op = 4'hF; d.b = iu; end
      7'h17: begin d.a = p; d.b = iu; end
      7'h6F, 7'h67: begin d.a = p; d.b = 32'd4; end
      7'h03: begin d.a = r1; d.b = ii; end
      7'h23: begin d.a = r1; d.b = is_; wr = 1'b0; end
      7'h63: begin d.op = 4'h8; d.a = r1; d.b = r2; wr = 1'b0; end
      default: ok = 1'b0;
    endcase
    if (!ok) begin
      d.op = 4'h0; d.a = 32'h0; d.b = 32'h0; d.ill = 1'b1; wr = 1'b0;
    end
    d.wren = wr && (ins[11:7] != 5'd0);
    return d;
  endfunction
  task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic step();
    logic acc, drn;
    acc = i_valid && (!m_valid || i_ready) && !i_flush;
    drn = m_valid && i_ready;
`ifdef ALU_ISSUE_PERF_EN
    if (drn) m_issue = m_issue + 1;
    if (m_valid && !i_ready) m_stall = m_stall + 1;
`endif
    if (i_flush) m_valid = 1'b0;
    else if (acc) begin
      m_valid = 1'b1;
      m_out = ref_dec(instr, pc, rs1, rs2);
    end else if (drn) m_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask
  task automatic check_all(string nm);
    chk({nm, " valid"}, 128'(o_valid), 128'(m_valid));
    chk({nm, " data"}, 128'(w_act), 128'(m_out));
`ifdef ALU_ISSUE_PERF_EN
    chk({nm, " issue_cnt"}, 128'(o_issue_cnt), 128'(m_issue));
    chk({nm, " stall_cnt"}, 128'(o_stall_cnt), 128'(m_stall));
`endif
  endtask
  task automatic drive(vec_t v, logic vld, logic rdy, logic fl);
    instr = v.instr; pc = v.pc; rs1 = v.rs1; rs2 = v.rs2;
    i_valid = vld; i_ready = rdy; i_flush = fl;
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    m_valid = 1'b0; m_out = '0; m_issue = '0; m_stall = '0;
    #2;
    chk("reset valid", 128'(o_valid), 128'(0));
    chk("reset ready", 128'(o_ready), 128'(1));
    chk("reset data", 128'(w_act), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  function automatic logic [31:0] rand_instr();
    logic [6:0] opcs[9];
    logic [6:0] f7;
    opcs = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h23, 7'h63};
    if ($urandom_range(7) == 0) return $urandom;
    f7 = ($urandom_range(2) == 0) ? 7'h00 : ($urandom_range(1) == 0) ? 7'h20 : 7'($urandom);
    return {f7, 18'($urandom), opcs[$urandom_range(8)]};
  endfunction
  initial begin
    vt[0]  = mk(32'h402081B3, 32'h100, 32'd10, 32'd3, 4'h8, 32'd10, 32'd3, 5'd3, 1, 0);
    vt[1]  = mk(32'h40435293, 32'h104, 32'h80000000, 32'd0, 4'hD, 32'h80000000, 32'h404, 5'd5, 1, 0);
    vt[2]  = mk(32'h123450B7, 32'h108, 32'd55, 32'd66, 4'hF, 32'd0, 32'h12345000, 5'd1, 1, 0);
    vt[3]  = mk(32'hFFFFFFFF, 32'h10C, 32'd1, 32'd2, 4'h0, 32'd0, 32'd0, 5'd31, 0, 1);
    vt[4]  = mk(32'hABCDE117, 32'h1000, 32'd7, 32'd8, 4'h0, 32'h1000, 32'hABCDE000, 5'd2, 1, 0);
    vt[5]  = mk(32'h000000EF, 32'h2000, 32'd7, 32'd8, 4'h0, 32'h2000, 32'd4, 5'd1, 1, 0);
    vt[6]  = mk(32'hFE512E23, 32'h110, 32'h400, 32'd9, 4'h0, 32'h400, 32'hFFFFFFFC, 5'd28, 0, 0);
    vt[7]  = mk(32'h00208063, 32'h114, 32'd5, 32'd6, 4'h8, 32'd5, 32'd6, 5'd0, 0, 0);
    vt[8]  = mk(32'h40109213, 32'h118, 32'd1, 32'd2, 4'h0, 32'd0, 32'd0, 5'd4, 0, 1);
    vt[9]  = mk(32'h4020C1B3, 32'h11C, 32'd1, 32'd2, 4'h0, 32'd0, 32'd0, 5'd3, 0, 1);
    vt[10] = mk(32'h00500013, 32'h120, 32'd9, 32'd9, 4'h0, 32'd9, 32'd5, 5'd0, 0, 0);
    vt[11] = mk(32'h0080A383, 32'h124, 32'h1000, 32'd0, 4'h0, 32'h1000, 32'd8, 5'd7, 1, 0);
    vt[12] = mk(32'hFFF0B313, 32'h128, 32'd3, 32'd0, 4'h3, 32'd3, 32'hFFFFFFFF, 5'd6, 1, 0);
    vt[13] = mk(32'h000280E7, 32'h12C, 32'h44, 32'd0, 4'h0, 32'h12C, 32'd4, 5'd1, 1, 0);
    do_reset();
    for (int k = 0; k < 14; k++) begin
      drive(vt[k], 1'b1, 1'b1, 1'b0);
      step();
      chk($sformatf("vec%0d", k), {o_valid, w_act}, {1'b1, vt[k].exp});
    end
    i_valid = 1'b0;
    rst_n = 1'b0;
    m_valid = 1'b0; m_out = '0; m_issue = '0; m_stall = '0;
    #1;
    chk("async reset valid", 128'(o_valid), 128'(0));
    chk("async reset data", 128'(w_act), 128'(0));
    chk("async reset ready", 128'(o_ready), 128'(1));
    @(negedge clk);
    rst_n = 1'b1;
    drive(vt[0], 1'b1, 1'b0, 1'b0);
    step();
    chk("stall load", {o_valid, w_act}, {1'b1, vt[0].exp});
    drive(vt[2], 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("stall%0d ready", k), 128'(o_ready), 128'(0));
      step();
      chk($sformatf("stall%0d hold", k), {o_valid, w_act}, {1'b1, vt[0].exp});
    end
    i_ready = 1'b1;
    #1;
    chk("unstall ready", 128'(o_ready), 128'(1));
    step();
    chk("unstall capture", {o_valid, w_act}, {1'b1, vt[2].exp});
    drive(vt[3], 1'b1, 1'b1, 1'b1);
    step();
    chk("flush drop", {o_valid, w_act}, {1'b0, vt[2].exp});
    i_flush = 1'b0;
    step();
    chk("illegal issue", {o_valid, w_act}, {1'b1, vt[3].exp});
    i_valid = 1'b0;
    step();
    chk("drain", 128'(o_valid), 128'(0));
    for (int k = 0; k < 600; k++) begin
      instr = rand_instr(); pc = $urandom; rs1 = $urandom; rs2 = $urandom;
      i_valid = ($urandom_range(3) != 0);
      i_ready = ($urandom_range(2) != 0);
      i_flush = ($urandom_range(9) == 0);
      #1;
      chk($sformatf("rand%0d ready", k), 128'(o_ready), 128'(!m_valid || i_ready));
      step();
      check_all($sformatf("rand%0d", k));
    end
`ifdef ALU_ISSUE_PERF_EN
    i_valid = 1'b0; i_flush = 1'b0;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      drive(vt[k], 1'b1, 1'b1, 1'b0);
      step();
    end
    drive(vt[0], 1'b0, 1'b0, 1'b0);
    repeat (3) step();
    i_ready = 1'b1;
    step();
    chk("perf issue", 128'(o_issue_cnt), 128'(5));
    chk("perf stall", 128'(o_stall_cnt), 128'(3));
    check_all("perf");
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
